// File: rtl/pc_seq_ctrl.sv
// Pipeline sequencing controller: decides what the PC loads and which pipeline
// registers hold or flush. Sources are arbitrated: exception > branch > mult/div > load-use.
module pc_seq_ctrl #(
   parameter int unsigned MD_LATENCY = 8,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] pc_plus4,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        id_md_use,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rt,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        md_start,
   input  logic        exc_req,
   input  logic [31:0] exc_pc,
   output logic [31:0] pc_result,
   output logic        pc_stall,
   output logic        ifid_stall,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        md_busy,
   output logic [31:0] epc
);

   localparam int unsigned CW = $clog2(MD_LATENCY);
   localparam logic [1:0] ST_RUN       = 2'd0;
   localparam logic [1:0] ST_MD_WAIT   = 2'd1;
   localparam logic [1:0] ST_EXC_FLUSH = 2'd2;
   localparam logic [CW-1:0] MD_LOAD   = CW'(MD_LATENCY - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] md_cnt_q, md_cnt_d;
   logic [31:0]   epc_q, epc_d;

   logic in_flush;
   logic in_md_wait;
   logic load_use;
   logic md_stall;

   assign in_flush   = (state_q == ST_EXC_FLUSH);
   assign in_md_wait = (state_q == ST_MD_WAIT);

   // A load to $0 never produces a value worth waiting for.
   assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   assign md_stall = in_md_wait && id_md_use;

   // Next-state, count and EPC
   always_comb begin
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      epc_d    = epc_q;
      case (state_q)
         ST_RUN, ST_MD_WAIT: begin
            if (exc_req) begin
               epc_d    = exc_pc;
               md_cnt_d = '0;
               state_d  = ST_EXC_FLUSH;
            end else if (md_start) begin
               md_cnt_d = MD_LOAD;
               state_d  = ST_MD_WAIT;
            end else if (in_md_wait) begin
               if (md_cnt_q == '0) begin
                  state_d = ST_RUN;
               end else begin
                  md_cnt_d = md_cnt_q - CW'(1);
               end
            end
         end
         ST_EXC_FLUSH: begin
            md_cnt_d = '0;
            state_d  = ST_RUN;
         end
         default: begin
            md_cnt_d = '0;
            state_d  = ST_RUN;
         end
      endcase
   end

   // Output arbitration; only the winning source drives the outputs.
   always_comb begin
      pc_result  = pc_plus4;
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (in_flush) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (exc_req) begin
         pc_result  = EXC_VECTOR;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (br_taken) begin
         // The ID instruction is squashed, so any pending stall is moot.
         pc_result  = br_target;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (md_stall || load_use) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         idex_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_RUN;
         md_cnt_q <= '0;
         epc_q    <= '0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
         epc_q    <= epc_d;
      end
   end

   assign md_busy = in_md_wait;
   assign epc     = epc_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed test-plan steps then randomized cycles,
// all checked against a cycle-level reference model of the sequencing rules.
module tb_pc_seq_ctrl;

   localparam int MD_LAT = 8;
   localparam logic [31:0] EVEC = 32'h0000_0180;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] pc_plus4, br_target, exc_pc;
   logic [4:0]  id_rs, id_rt, ex_rt;
   logic        id_uses_rt, id_md_use, ex_mem_read, br_taken, md_start, exc_req;
   logic [31:0] pc_result, epc;
   logic        pc_stall, ifid_stall, ifid_flush, idex_flush, md_busy;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: busy cycles remaining, flush cycle pending, saved EPC.
   int          m_left;
   bit          m_flush;
   logic [31:0] m_epc;

   pc_seq_ctrl #(.MD_LATENCY(MD_LAT), .EXC_VECTOR(EVEC)) dut (
      .clk(clk), .reset_n(reset_n), .pc_plus4(pc_plus4),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_md_use(id_md_use),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .br_taken(br_taken),
      .br_target(br_target), .md_start(md_start), .exc_req(exc_req), .exc_pc(exc_pc),
      .pc_result(pc_result), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .md_busy(md_busy), .epc(epc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      pc_plus4 = 32'h0000_1004; br_target = 32'h0; exc_pc = 32'h0;
      id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
      id_uses_rt = 1'b0; id_md_use = 1'b0; ex_mem_read = 1'b0;
      br_taken = 1'b0; md_start = 1'b0; exc_req = 1'b0;
   endtask

   task automatic model_reset();
      m_left = 0; m_flush = 1'b0; m_epc = 32'h0;
   endtask

   // One clock: check outputs against the model mid-cycle, then advance the model.
   task automatic cyc();
      logic [31:0] e_pc;
      logic        e_stall, e_iff, e_xf;
      bit          busy, hz;
      @(negedge clk);
      busy = (m_left > 0);
      hz = ex_mem_read && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      e_pc = pc_plus4; e_stall = 1'b0; e_iff = 1'b0; e_xf = 1'b0;
      if (m_flush) begin
         e_iff = 1'b1; e_xf = 1'b1;
      end else if (exc_req) begin
         e_pc = EVEC; e_iff = 1'b1; e_xf = 1'b1;
      end else if (br_taken) begin
         e_pc = br_target; e_iff = 1'b1; e_xf = 1'b1;
      end else if ((busy && id_md_use) || hz) begin
         e_stall = 1'b1; e_xf = 1'b1;
      end
      check("pc_result",  pc_result,  e_pc);
      check("pc_stall",   {31'd0, pc_stall},   {31'd0, e_stall});
      check("ifid_stall", {31'd0, ifid_stall}, {31'd0, e_stall});
      check("ifid_flush", {31'd0, ifid_flush}, {31'd0, e_iff});
      check("idex_flush", {31'd0, idex_flush}, {31'd0, e_xf});
      check("md_busy",    {31'd0, md_busy},    {31'd0, busy});
      check("epc",        epc,        m_epc);
      if (m_flush) begin
         m_flush = 1'b0;
      end else if (exc_req) begin
         m_flush = 1'b1; m_left = 0; m_epc = exc_pc;
      end else if (md_start) begin
         m_left = MD_LAT;
      end else if (m_left > 0) begin
         m_left--;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      model_reset();
      reset_n = 1'b0;
      #3;
      check("rst_busy", {31'd0, md_busy}, 32'd0);
      check("rst_epc", epc, 32'd0);
      check("rst_pc", pc_result, 32'h0000_1004);
      check("rst_stall", {30'd0, pc_stall, idex_flush}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Load-use hazard stalls one cycle, bubble clears it; $0 never stalls
      ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
      cyc();
      ex_mem_read = 1'b0;
      cyc();
      ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      cyc();
      ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; id_rs = 5'd3;
      cyc();

      // Branch overrides the hazard
      br_taken = 1'b1; br_target = 32'h40;
      #1;
      check("br_hz_pc", pc_result, 32'h40);
      check("br_hz_stall", {31'd0, pc_stall}, 32'd0);
      cyc();
      idle();

      // Mult/div with restart at cycle 4
      md_start = 1'b1;
      cyc();
      md_start = 1'b0; id_md_use = 1'b1;
      repeat (3) cyc();
      md_start = 1'b1;
      cyc();
      md_start = 1'b0;
      repeat (10) cyc();
      idle();

      // Exception beats a same-cycle branch; EXC_FLUSH ignores both
      exc_req = 1'b1; exc_pc = 32'h1C; br_taken = 1'b1; br_target = 32'h40;
      #1;
      check("exc_pc_vec", pc_result, 32'h180);
      cyc();
      check("epc_saved", epc, 32'h1C);
      exc_pc = 32'h99;
      cyc();
      idle();
      cyc();
      check("epc_kept", epc, 32'h1C);

      // Exception at cycle 3 of a mult/div wait; also exc+md_start together
      md_start = 1'b1;
      cyc();
      md_start = 1'b0; id_md_use = 1'b1;
      repeat (2) cyc();
      exc_req = 1'b1; exc_pc = 32'h2000;
      cyc();
      exc_req = 1'b0;
      check("exc_md_busy", {31'd0, md_busy}, 32'd0);
      repeat (2) cyc();
      exc_req = 1'b1; md_start = 1'b1; exc_pc = 32'h3000;
      cyc();
      idle();
      repeat (2) cyc();

      // Async reset mid-MD_WAIT clears state without a clock edge
      md_start = 1'b1;
      cyc();
      md_start = 1'b0; id_md_use = 1'b1;
      repeat (2) cyc();
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, md_busy}, 32'd0);
      check("arst_epc", epc, 32'd0);
      check("arst_stall", {31'd0, pc_stall}, 32'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      cyc();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         pc_plus4    = $urandom;
         br_target   = $urandom;
         exc_pc      = $urandom;
         id_rs       = 5'($urandom_range(0, 3));
         id_rt       = 5'($urandom_range(0, 3));
         ex_rt       = 5'($urandom_range(0, 3));
         id_uses_rt  = 1'($urandom_range(0, 1));
         id_md_use   = 1'($urandom_range(0, 1));
         ex_mem_read = 1'($urandom_range(0, 1));
         br_taken    = ($urandom_range(0, 7) == 0);
         md_start    = ($urandom_range(0, 9) == 0);
         exc_req     = ($urandom_range(0, 15) == 0);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
